add_accum_mc: RTL
=================

ADD_ACCUM_MC -- requirements
Module: add_accum_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data and accumulator width in bits, minimum 2.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent accumulators, range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an input beat.
REQ-007 SHALL have port in_chan, input, $clog2(CHANNELS) bits (minimum 1): target channel.
REQ-008 SHALL have port in_data, input, WIDTH bits: unsigned addend.
REQ-009 SHALL have port in_clear, input, 1 bit: load in_data instead of adding, and clear the channel's sticky overflow.
REQ-010 SHALL have port sat_mode, input, 1 bit: 0 selects wrap-around, 1 selects saturation; sampled at accept.
REQ-011 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result beat.
REQ-013 SHALL have port out_chan, output, same width as in_chan: channel of the result.
REQ-014 SHALL have port out_accum, output, WIDTH bits: new accumulator value.
REQ-015 SHALL have port out_overflow, output, 1 bit: sticky overflow flag of the channel after this update.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready); an accept occurs when in_valid && in_ready.
REQ-017 On accept, the block SHALL compute sum = acc[in_chan] + in_data at WIDTH+1 bits; carry = sum[WIDTH].
REQ-018 In wrap mode, acc[in_chan] SHALL become sum[WIDTH-1:0].
REQ-019 In saturate mode, acc[in_chan] SHALL become all-ones when carry=1, else sum[WIDTH-1:0].
REQ-020 Sticky ovf[in_chan] SHALL be set when carry=1 in either mode, and SHALL stay set until in_clear or reset.
REQ-021 With in_clear=1, acc[in_chan] SHALL become in_data, ovf[in_chan] SHALL become 0, and no carry SHALL be evaluated.
REQ-022 Output registers SHALL load on accept; latency is 1 cycle from accept to out_valid=1.
REQ-023 While out_valid=1 && out_ready=0, out_chan, out_accum and out_overflow SHALL stay stable, and in_ready SHALL be 0.
REQ-024 Accept and output handoff in the same cycle SHALL sustain one beat per cycle.
REQ-025 Back-to-back accepts to the same channel SHALL use the updated value with no bubble and no hazard.
REQ-026 An accept with in_chan >= CHANNELS SHALL be consumed with no state change and no output beat.
REQ-027 Untargeted channels SHALL hold their value.

Reset
REQ-028 While reset=1 at a clock edge: all acc SHALL be 0, all ovf 0, out_valid 0, out_chan 0, out_accum 0, out_overflow 0.
REQ-029 A beat in flight or held at the output SHALL be discarded on reset.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro ADD_ACCUM_SAT_EN defined: saturate mode SHALL be available as in REQ-019.
REQ-032 Macro ADD_ACCUM_SAT_EN undefined: sat_mode SHALL be ignored, wrap SHALL always apply, no saturation logic SHALL be built, and ovf SHALL still be tracked.

Structure
REQ-033 Package add_accum_pkg SHALL hold the mode constants (ACC_MODE_WRAP=0, ACC_MODE_SAT=1) and the default WIDTH/CHANNELS constants.
REQ-034 A combinational sub-module accum_sat_add SHALL be provided (a, b, sat -> result, carry); the saturation path is guarded by ADD_ACCUM_SAT_EN.
REQ-035 The accumulator and overflow arrays and the output register SHALL reside in add_accum_mc.

Verification (WIDTH=4, CHANNELS=4)
REQ-036 Clear-load: ch0 clear with 5, then add 3 -> out_accum 5 then 8, out_overflow 0, 1-cycle latency each.
REQ-037 Wrap: ch1 load 12, add 7, sat_mode=0 -> out_accum 3, out_overflow 1; next add 1 -> 4, out_overflow stays 1.
REQ-038 Saturate (macro on): ch2 load 12, add 7, sat_mode=1 -> 15, ovf 1; macro off -> 3, ovf 1.
REQ-039 Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0 and outputs stable; first out_ready=1 cycle -> handoff plus new accept.
REQ-040 Interleave: 1 per cycle to ch0,ch3,ch0,ch3 adding 1 from 0 -> results 1,1,2,2; in_chan 3 must not disturb ch0.
REQ-041 Reset mid-stream: reset during stalled output -> out_valid 0 next cycle, all channels read 0 on subsequent add-0 beats.

Source files
------------

// File: rtl/add_accum_pkg.sv
// Shared constants for the multi-channel add/accumulate block.
// Holds the mode encoding, the default sizes and the channel-index width helper.
package add_accum_pkg;

    localparam int ACC_WIDTH_DEFAULT    = 8;
    localparam int ACC_CHANNELS_DEFAULT = 4;

    typedef enum logic {
        ACC_MODE_WRAP = 1'b0,
        ACC_MODE_SAT  = 1'b1
    } acc_mode_e;

    // A single-channel build still carries a 1-bit channel field.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Combinational WIDTH-bit unsigned adder with carry-out and optional clamp to all-ones.
// The clamp is only built when ADD_ACCUM_SAT_EN is defined; otherwise the result always wraps.
module accum_sat_add
    import add_accum_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign carry = sum[WIDTH];

`ifdef ADD_ACCUM_SAT_EN
    assign result = (sat && carry) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    // Without saturation support the mode input has no effect.
    logic sat_unused;
    assign sat_unused = sat;
    assign result     = sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/add_accum_mc.sv
// Multi-channel accumulator: one add (or load) per accepted beat, registered result with valid/ready.
// Saturation mode is available only when ADD_ACCUM_SAT_EN is defined; overflow is tracked either way.
module add_accum_mc
    import add_accum_pkg::*;
#(
    parameter int WIDTH    = ACC_WIDTH_DEFAULT,
    parameter int CHANNELS = ACC_CHANNELS_DEFAULT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [chan_width(CHANNELS)-1:0]     in_chan,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic                                in_clear,
    input  logic                                sat_mode,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [chan_width(CHANNELS)-1:0]     out_chan,
    output logic [WIDTH-1:0]                    out_accum,
    output logic                                out_overflow
);

    localparam int CW = chan_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] acc_flat;
    logic [CHANNELS-1:0]       ovf_flat;

    logic                      accept;
    logic                      chan_ok;
    logic                      wr_en;
    logic                      sat_sel;
    logic [WIDTH-1:0]          acc_sel;
    logic                      ovf_sel;
    logic [WIDTH-1:0]          add_result;
    logic                      add_carry;
    logic [WIDTH-1:0]          acc_d;
    logic                      ovf_d;

    logic                      out_valid_q, out_valid_d;
    logic [CW-1:0]             out_chan_q, out_chan_d;
    logic [WIDTH-1:0]          out_accum_q, out_accum_d;
    logic                      out_overflow_q, out_overflow_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign chan_ok  = (32'(in_chan) < CHANNELS);
    assign wr_en    = accept && chan_ok;
    assign sat_sel  = (sat_mode == ACC_MODE_SAT);

    // Current state of the addressed channel; always the freshest value, so back-to-back beats need no bypass.
    always_comb begin
        acc_sel = '0;
        ovf_sel = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (32'(in_chan) == i) begin
                acc_sel = acc_flat[i*WIDTH +: WIDTH];
                ovf_sel = ovf_flat[i];
            end
        end
    end

    accum_sat_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a      (acc_sel),
        .b      (in_data),
        .sat    (sat_sel),
        .result (add_result),
        .carry  (add_carry)
    );

    // A clear loads the addend verbatim and ignores any carry.
    always_comb begin
        acc_d = add_result;
        ovf_d = ovf_sel | add_carry;
        if (in_clear) begin
            acc_d = in_data;
            ovf_d = 1'b0;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [WIDTH-1:0] acc_q;
        logic             ovf_q;
        logic             hit;

        assign hit = wr_en && (32'(in_chan) == gi);

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (hit) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
        end

        assign acc_flat[gi*WIDTH +: WIDTH] = acc_q;
        assign ovf_flat[gi]                = ovf_q;
    end

    // Out-of-range channels are consumed silently: the held beat may still drain, but nothing new is loaded.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_chan_d     = out_chan_q;
        out_accum_d    = out_accum_q;
        out_overflow_d = out_overflow_q;
        if (wr_en) begin
            out_valid_d    = 1'b1;
            out_chan_d     = in_chan;
            out_accum_d    = acc_d;
            out_overflow_d = ovf_d;
        end else if (out_ready) begin
            out_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_chan_q     <= '0;
            out_accum_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_chan_q     <= out_chan_d;
            out_accum_q    <= out_accum_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_chan     = out_chan_q;
    assign out_accum    = out_accum_q;
    assign out_overflow = out_overflow_q;

endmodule
